// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with an optional direct-mapped BTB (enabled by FETCH_BTB_EN).
// Picks the next PC from redirect, stall, predicted-taken target or PC+4.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isBranchTakenPredicted,
  input  logic        fetchReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        btbUpdateValid,
  input  logic [31:0] btbUpdatePc,
  input  logic [31:0] btbUpdateTarget,
  output logic        fetchValid,
  output logic [31:0] fetchPc,
  output logic        predictedTaken,
  output logic [31:0] predictedTarget
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        btb_hit;
  logic [29:0] btb_lookup_target;
  logic        unused_bits;

`ifdef FETCH_BTB_EN
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [29:0]            btb_target_q [BTB_ENTRIES];
  logic [IDX-1:0]         lookup_idx;
  logic [IDX-1:0]         update_idx;

  assign lookup_idx = pc_q[IDX+1:2];
  assign update_idx = btbUpdatePc[IDX+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (btbUpdateValid) begin
      btb_valid_q[update_idx] <= 1'b1;
    end
  end

  // NOTE: tag/target storage has no reset; the valid bits alone gate every hit,
  // so the arrays can stay plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (btbUpdateValid) begin
      btb_tag_q[update_idx]    <= btbUpdatePc[31:IDX+2];
      btb_target_q[update_idx] <= btbUpdateTarget[31:2];
    end
  end

  assign btb_hit           = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == pc_q[31:IDX+2]);
  assign btb_lookup_target = btb_target_q[lookup_idx];
  assign unused_bits       = ^{redirectPc[1:0], btbUpdatePc[1:0], btbUpdateTarget[1:0]};
`else
  assign btb_hit           = 1'b0;
  assign btb_lookup_target = '0;
  assign unused_bits       = ^{redirectPc[1:0], btbUpdateValid, btbUpdatePc, btbUpdateTarget};
`endif

  assign pc_plus4        = pc_q + 32'd4;
  assign fetchValid      = valid_q;
  assign fetchPc         = pc_q;
  assign predictedTaken  = btb_hit && isBranchTakenPredicted;
  assign predictedTarget = predictedTaken ? {btb_lookup_target, 2'b00} : pc_plus4;

  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (redirectValid) begin
      pc_d    = {redirectPc[31:2], 2'b00};
      valid_d = 1'b1;
    end else if (!valid_q) begin
      valid_d = 1'b1;
    end else if (fetchReady) begin
      pc_d = predictedTarget;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized self-checking bench for fetch_pc_unit against a word-address reference model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam int          ENTRIES = 16;
`ifdef FETCH_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        taken_i = 1'b0, ready_i = 1'b1, rv_i = 1'b0, uv_i = 1'b0;
  logic [31:0] rpc_i = '0, upc_i = '0, utgt_i = '0;
  logic        fetch_valid, pred_taken;
  logic [31:0] fetch_pc, pred_target;

  int checks   = 0;
  int failures = 0;

  // Reference model: BTB keyed by the full word address of the branch.
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_vld [ENTRIES];
  logic [31:0] m_bpc [ENTRIES];
  logic [31:0] m_btgt[ENTRIES];

  fetch_pc_unit #(.RESET_PC(RST_PC), .BTB_ENTRIES(ENTRIES)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .isBranchTakenPredicted (taken_i),
    .fetchReady             (ready_i),
    .redirectValid          (rv_i),
    .redirectPc             (rpc_i),
    .btbUpdateValid         (uv_i),
    .btbUpdatePc            (upc_i),
    .btbUpdateTarget        (utgt_i),
    .fetchValid             (fetch_valid),
    .fetchPc                (fetch_pc),
    .predictedTaken         (pred_taken),
    .predictedTarget        (pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_taken(input logic t);
    int idx;
    idx = int'((m_pc >> 2) % ENTRIES);
    return BTB_EN && t && m_vld[idx] && ((m_bpc[idx] >> 2) == (m_pc >> 2));
  endfunction

  function automatic logic [31:0] m_target(input logic t);
    int idx;
    idx = int'((m_pc >> 2) % ENTRIES);
    return m_taken(t) ? m_btgt[idx] : m_pc + 32'd4;
  endfunction

  function automatic void m_reset();
    m_pc    = RST_PC;
    m_valid = 1'b0;
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
  endfunction

  function automatic void m_step(input logic rdy, input logic t, input logic rv, input logic [31:0] rpc,
                                 input logic uv, input logic [31:0] upc, input logic [31:0] utgt);
    logic [31:0] nxt;
    int idx;
    nxt = m_target(t);
    if (rv) begin
      m_pc    = rpc & ~32'd3;
      m_valid = 1'b1;
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (rdy) begin
      m_pc = nxt;
    end
    if (BTB_EN && uv) begin
      idx         = int'((upc >> 2) % ENTRIES);
      m_vld[idx]  = 1'b1;
      m_bpc[idx]  = upc;
      m_btgt[idx] = utgt & ~32'd3;
    end
  endfunction

  // Called at a falling edge; drives one cycle of inputs, checks, and returns at the next falling edge.
  task automatic cycle(input logic rdy, input logic t, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt);
    ready_i = rdy; taken_i = t; rv_i = rv; rpc_i = rpc; uv_i = uv; upc_i = upc; utgt_i = utgt;
    #1;
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
    check("fetch_pc", fetch_pc, m_pc);
    check("pred_taken", {31'd0, pred_taken}, {31'd0, m_taken(t)});
    check("pred_target", pred_target, m_target(t));
    @(posedge clk);
    m_step(rdy, t, rv, rpc, uv, upc, utgt);
    @(negedge clk);
  endtask

  task automatic go(input logic rdy, input logic t);
    cycle(rdy, t, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    cycle(1'b0, 1'b0, 1'b1, pc, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic btb_write(input logic [31:0] pc, input logic [31:0] tgt);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, pc, tgt);
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_pc", fetch_pc, RST_PC);
    check("rst_ptaken", {31'd0, pred_taken}, 32'd0);
    check("rst_ptarget", pred_target, RST_PC + 32'd4);
    rst = 1'b0;

    go(1'b1, 1'b0);
    check("first_pc", fetch_pc, 32'h100);
    check("first_valid", {31'd0, fetch_valid}, 32'd1);
    go(1'b1, 1'b0);
    check("seq_104", fetch_pc, 32'h104);
    go(1'b1, 1'b0);
    check("seq_108", fetch_pc, 32'h108);

    btb_write(32'h10C, 32'h200);
    repeat (2) go(1'b0, 1'b0);
    check("stall_pc", fetch_pc, 32'h108);
    check("stall_valid", {31'd0, fetch_valid}, 32'd1);
    go(1'b1, 1'b0);
    check("after_stall", fetch_pc, 32'h10C);
    go(1'b0, 1'b1);
    check("hit_taken", {31'd0, pred_taken}, {31'd0, BTB_EN});
    go(1'b1, 1'b1);
    check("taken_next", fetch_pc, BTB_EN ? 32'h200 : 32'h110);

    redirect(32'h10C);
    go(1'b1, 1'b0);
    check("nottaken_next", fetch_pc, 32'h110);

    redirect(32'h200);
    redirect(32'h403);
    check("redirect_pc", fetch_pc, 32'h400);
    check("redirect_valid", {31'd0, fetch_valid}, 32'd1);

    redirect(32'h14C);
    go(1'b0, 1'b1);
    check("alias_nohit", {31'd0, pred_taken}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h14C, 32'h300);
    check("alias_hit", {31'd0, pred_taken}, {31'd0, BTB_EN});
    check("alias_target", pred_target, BTB_EN ? 32'h300 : 32'h150);
    redirect(32'h10C);
    go(1'b0, 1'b1);
    check("evicted_nohit", {31'd0, pred_taken}, 32'd0);

    redirect(32'hFFFF_FFFC);
    go(1'b1, 1'b0);
    check("wrap_pc", fetch_pc, 32'h0);

    redirect(32'h14C);
    repeat (3) go(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    ready_i = 1'b1; taken_i = 1'b0; rv_i = 1'b0; uv_i = 1'b0;
    #1;
    check("async_valid", {31'd0, fetch_valid}, 32'd0);
    check("async_pc", fetch_pc, RST_PC);
    m_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    m_step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("restart_pc", fetch_pc, RST_PC);
    redirect(32'h14C);
    go(1'b0, 1'b1);
    check("btb_cleared", {31'd0, pred_taken}, 32'd0);

    for (int n = 0; n < 600; n++) begin
      logic        rdy, t, rv, uv;
      logic [31:0] rpc, upc, utgt;
      rdy  = ($urandom_range(0, 3) != 0);
      t    = $urandom_range(0, 1) != 0;
      rv   = ($urandom_range(0, 15) == 0);
      uv   = ($urandom_range(0, 3) == 0);
      rpc  = 32'h100 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
      upc  = 32'h100 + (32'($urandom_range(0, 63)) << 2);
      utgt = 32'h100 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
      cycle(rdy, t, rv, rpc, uv, upc, utgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
